// File: rtl/gemm_pp_src_buf.sv
// Ping-pong operand buffer for the GEMM datapath: the loader fills one bank while the compute array reads the other.
// Optional sticky illegal-access flag enabled by defining GEMM_PP_BUF_ERR_EN.
module gemm_pp_src_buf #(
    parameter int DW = 32,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          src_v,
    input  logic [AW-1:0] src_a,
    input  logic [DW-1:0] src_d,
    input  logic          src_last,
    output logic          src_rdy,
    input  logic          exec,
    input  logic [AW-1:0] ia,
    input  logic          exec_last,
    output logic          exec_rdy,
    output logic [DW-1:0] d,
    output logic [1:0]    full_cnt,
    output logic          err
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [2][DEPTH];
    logic          wb;
    logic          rb;
    logic [1:0]    full;
    logic          wr_acc;
    logic          rd_acc;
    logic          wr_in_range;
    logic          rd_in_range;

    assign src_rdy     = !full[wb];
    assign exec_rdy    = full[rb];
    assign full_cnt    = {1'b0, full[0]} + {1'b0, full[1]};
    assign wr_acc      = src_v && src_rdy;
    assign rd_acc      = exec && exec_rdy;
    assign wr_in_range = {1'b0, src_a} < DEPTH_W;
    assign rd_in_range = {1'b0, ia} < DEPTH_W;

    // Storage is never reset; a write in the reset cycle is ignored.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc && wr_in_range) begin
            mem[wb][src_a] <= src_d;
        end
    end

    // An accepted write and read always target different banks, so the two
    // flag updates never touch the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb   <= 1'b0;
            rb   <= 1'b0;
            full <= 2'b00;
            d    <= '0;
        end else begin
            if (wr_acc && src_last) begin
                full[wb] <= 1'b1;
                wb       <= ~wb;
            end
            if (rd_acc) begin
                d <= rd_in_range ? mem[rb][ia] : '0;
                if (exec_last) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                end
            end
        end
    end

`ifdef GEMM_PP_BUF_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((src_v && !src_rdy) || (exec && !exec_rdy)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gemm_pp_src_buf.sv
// Scoreboard bench for gemm_pp_src_buf: a bank-order queue model predicts flags and read data.
// Honours GEMM_PP_BUF_ERR_EN for the expected err behaviour.
module tb_gemm_pp_src_buf;

    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          src_v;
    logic [AW-1:0] src_a;
    logic [DW-1:0] src_d;
    logic          src_last;
    logic          src_rdy;
    logic          exec;
    logic [AW-1:0] ia;
    logic          exec_last;
    logic          exec_rdy;
    logic [DW-1:0] d;
    logic [1:0]    full_cnt;
    logic          err;

    int assertCount = 0;
    int failCount = 0;

    // Reference model: full banks form an in-order queue of bank ids.
    int          ready_q[$];
    int          fill_bank = 0;
    logic [31:0] bank_mem [2][DEPTH];
    logic [31:0] exp_q[$];
    logic [31:0] exp_d = '0;
    bit          exp_err = 1'b0;
    bit          rd_pend = 1'b0;

    gemm_pp_src_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .src_v(src_v), .src_a(src_a), .src_d(src_d), .src_last(src_last), .src_rdy(src_rdy),
        .exec(exec), .ia(ia), .exec_last(exec_last), .exec_rdy(exec_rdy),
        .d(d), .full_cnt(full_cnt), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bit wr_ok;
        bit rd_ok;
        if (reset) begin
            ready_q.delete();
            fill_bank = 0;
            exp_d = '0;
            exp_err = 1'b0;
            rd_pend = 1'b0;
        end else begin
            wr_ok = src_v && (ready_q.size() < 2);
            rd_ok = exec && (ready_q.size() > 0);
            if ((src_v && !wr_ok) || (exec && !rd_ok)) exp_err = 1'b1;
            rd_pend = rd_ok;
            if (rd_ok) begin
                exp_d = bank_mem[ready_q[0]][ia];
                exp_q.push_back(exp_d);
                if (exec_last) void'(ready_q.pop_front());
            end
            if (wr_ok) begin
                bank_mem[fill_bank][src_a] = src_d;
                if (src_last) begin
                    ready_q.push_back(fill_bank);
                    fill_bank = 1 - fill_bank;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] want;
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checkOutput("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                want = exp_q.pop_front();
                checkOutput("read_data", d, want);
            end
        end else begin
            checkOutput("d_hold", d, exp_d);
        end
        checkOutput("src_rdy", {31'd0, src_rdy}, {31'd0, ready_q.size() < 2});
        checkOutput("exec_rdy", {31'd0, exec_rdy}, {31'd0, ready_q.size() > 0});
        checkOutput("full_cnt", {30'd0, full_cnt}, 32'(ready_q.size()));
`ifdef GEMM_PP_BUF_ERR_EN
        checkOutput("err", {31'd0, err}, {31'd0, exp_err});
`else
        checkOutput("err", {31'd0, err}, 32'd0);
`endif
    end

    task automatic applyStimulus(input bit sv, input int sa, input logic [31:0] sd, input bit sl,
                                 input bit ex, input int ra, input bit el);
        src_v     = sv;
        src_a     = AW'(sa);
        src_d     = sd;
        src_last  = sl;
        exec      = ex;
        ia        = AW'(ra);
        exec_last = el;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);

        // Read on an empty buffer: dropped, d stays 0.
        applyStimulus(0, 0, '0, 0, 1, 7, 1);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;

        for (int a = 0; a < DEPTH; a++) applyStimulus(1, a, 100 + a, a == DEPTH - 1, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 5, 0);
        idle(3);

        // Refill bank 1 while draining bank 0; both lasts land on the same edge.
        for (int a = 0; a < DEPTH; a++)
            applyStimulus(1, a, 200 + a, a == DEPTH - 1, 1, a, a == DEPTH - 1);
        applyStimulus(0, 0, '0, 0, 1, 0, 0);

        for (int a = 0; a < DEPTH; a++) applyStimulus(1, a, $urandom, a == DEPTH - 1, 0, 0, 0);
        applyStimulus(1, 3, 32'hDEAD, 1, 0, 0, 0);
        applyStimulus(1, 9, 32'hDEAD, 0, 0, 0, 0);
        idle(1);
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, '0, 0, 1, a, a == DEPTH - 1);
        idle(2);

        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, DEPTH - 1), $urandom,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6,
                          $urandom_range(0, DEPTH - 1), $urandom_range(0, 15) == 0);

        // Drain whatever the random phase left, then reset mid-fill with one bank full.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 0, 1, i, 1);
        for (int a = 0; a < DEPTH; a++) applyStimulus(1, a, 300 + a, a == DEPTH - 1, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 2, 0);
        for (int a = 0; a < 10; a++) applyStimulus(1, a, 400 + a, 0, 0, 0, 0);
        reset = 1'b1;
        applyStimulus(1, 10, 32'hBEEF, 1, 1, 4, 1);
        reset = 1'b0;
        idle(2);
        for (int a = 0; a < DEPTH; a++) applyStimulus(1, a, $urandom, a == DEPTH - 1, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 12, 1);
        idle(3);

        if (exp_q.size() != 0) checkOutput("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/gemm_pp_src_buf.md
# gemm_pp_src_buf

Parametrised, double-buffered (ping-pong) operand buffer for the GEMM datapath, successor to the single-bank source buffer. The loader fills one bank while the compute array reads the other, so load and execute overlap instead of serialising. Bank ownership passes between the loader side and the compute side through per-bank full flags and explicit last-beat markers.

## Interface
- `DW`, 32: data width in bits.
- `DEPTH`, 32: words per bank, ≥2; `AW = $clog2(DEPTH)` is derived, not overridable.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `src_v`  in  1  write strobe from loader.
- `src_a`  in  AW  write address within current write bank.
- `src_d`  in  DW  write data.
- `src_last`  in  1  qualifies `src_v`; marks final write of a bank fill.
- `src_rdy`  out  1  write bank available (bank `wb` not full).
- `exec`  in  1  read strobe from compute array.
- `ia`  in  AW  read address within current read bank.
- `exec_last`  in  1  qualifies `exec`; marks final read of a bank.
- `exec_rdy`  out  1  a full bank is available to read (bank `rb` full).
- `d`  out  DW  registered read data.
- `full_cnt`  out  2  number of full banks (0..2).
- `err`  out  1  sticky illegal-access flag (see Configuration).

## Operation
- Storage: 2 banks × `DEPTH` × `DW`, not reset. Internal: write-bank pointer `wb`, read-bank pointer `rb`, flags `full[1:0]`.
- `src_rdy = !full[wb]`; `exec_rdy = full[rb]`; `full_cnt = full[0] + full[1]`.
- Write accepted when `src_v && src_rdy`: `mem[wb][src_a] <= src_d`. If also `src_last`: `full[wb] <= 1`, `wb <= ~wb`.
- Read accepted when `exec && exec_rdy`: `d <= mem[rb][ia]`. If also `exec_last`: `full[rb] <= 0`, `rb <= ~rb`.
- `src_v` without `src_rdy`: write dropped, no state change. `exec` without `exec_rdy`: `d` holds.
- `d` holds its value in every cycle with no accepted read.
- Out-of-range address (`≥ DEPTH`, non-power-of-2 only): write dropped but `src_last` still completes the fill; read loads `d <= 0`, `exec_last` still releases the bank.
- Simultaneous accepted write and read: always different banks (write needs `!full[wb]`, read needs `full[rb]`); both proceed in the same cycle, flag updates independent.
- Bank order strictly alternates 0,1,0,1 on both sides; no skipping, no reordering.

## Timing
- Reset values: `wb=0`, `rb=0`, `full=2'b00`, `d=0`, `err=0` → `src_rdy=1`, `exec_rdy=0`, `full_cnt=0`.
- Read latency 1: `d` valid the cycle after the accepted `exec`.
- Fill-to-read: `exec_rdy` rises the cycle after the accepted `src_last` write; first read issued that cycle returns data written in any earlier cycle, including the `src_last` beat.
- Release-to-refill: `src_rdy` (if previously low) rises the cycle after the accepted `exec_last` read.
- Both banks full: `src_rdy=0`, `full_cnt=2`. Both empty: `exec_rdy=0`, `full_cnt=0`.
- `reset` mid-operation: pointers, flags, `d`, `err` return to reset values next edge; bank contents retained but treated empty; accesses in the reset cycle ignored.

## Configuration
- `GEMM_PP_BUF_ERR_EN` defined: `err` sets on `src_v && !src_rdy` or `exec && !exec_rdy` and stays set until `reset`.
- Undefined: `err` tied to 0, no detection logic; illegal accesses still dropped as above.

## Test plan
- Reset then fill bank 0 with `src_d = 100+a`, `a=0..31`, `src_last` on `a=31` → `exec_rdy=1` next cycle, `full_cnt=1`, `src_rdy=1`.
- Read bank 0 `ia=5` → `d=105` one cycle later; hold `exec=0` 3 cycles → `d` stays 105.
- Fill bank 1 (`200+a`) while reading bank 0 every cycle, `exec_last` at `ia=31` on the same cycle bank 1's `src_last` lands → both banks correct, `rb=1`, `full_cnt=1`, next read `ia=0` returns 200.
- Fill both banks without reading → `src_rdy=0`, `full_cnt=2`; extra `src_v` with `src_d=DEAD` → no bank corrupted; with `GEMM_PP_BUF_ERR_EN`, `err=1`.
- `exec` on empty buffer after reset → `d` remains 0, `exec_rdy=0`; `err=1` only when macro defined.
- Assert `reset` mid-fill of bank 1 with bank 0 full → next cycle `full_cnt=0`, `wb=rb=0`, `d=0`, `src_rdy=1`, `exec_rdy=0`.
